// File: rtl/fifo_bist_element.sv
// BIST responder for a first-word-fall-through FIFO: fill with SEED+i, drain, check data and flags.
// Latency: a fault-free run reports on the shared done wire 2*DEPTH+3 cycles after en is sampled.
// Backpressure: none is waited on; full while filling or empty while draining aborts with fail set.
module fifo_bist_element #(
  parameter int          WIDTH = 8,
  parameter int          DEPTH = 4,
  parameter int unsigned SEED  = 32'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             fail,
  output wire              done,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  input  logic             full,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             empty
);

  localparam int             CW     = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  LAST   = CW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  typedef enum logic [2:0] {
    IDLE,
    CHECK0,
    WRITE,
    SETTLE_W,
    READ,
    SETTLE_R,
    REPORT
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    i_q;
  logic [CW-1:0]    i_inc;
  logic             fail_q;
  logic             done_q;
  logic             wr_q;
  logic             rd_q;
  logic [WIDTH-1:0] wr_data_q;

  // Pattern word idx; the sum wraps modulo 2^WIDTH on purpose.
  function automatic logic [WIDTH-1:0] pat(input logic [CW-1:0] idx);
    return SEED_W + WIDTH'(idx);
  endfunction

  assign i_inc = i_q + CW'(1);

  // Strobes come from registered state decodes; en gives an immediate stop when the
  // sequencer withdraws, and the live flags suppress a write into full / read from empty.
  assign wr_en   = wr_q & en & ~full;
  assign rd_en   = rd_q & en & ~empty;
  assign wr_data = wr_data_q;
  assign fail    = fail_q;

  // Only the enabled element that is reporting may drive the shared wire.
  assign done = (done_q && en) ? 1'b1 : 1'bz;

  // Test sequencer: fill, settle, drain, settle, report once per enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      i_q       <= '0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!en && state_q != IDLE) begin
        // Withdrawn enable: abandon the test, keep whatever fail already says.
        state_q <= IDLE;
        wr_q    <= 1'b0;
        rd_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (en) begin
              state_q <= CHECK0;
              i_q     <= '0;
              fail_q  <= 1'b0;
            end
          end
          CHECK0: begin
            if (!empty || full) fail_q <= 1'b1;
            state_q   <= WRITE;
            wr_q      <= 1'b1;
            wr_data_q <= pat('0);
          end
          WRITE: begin
            if (full) begin
              // A full flag before DEPTH words is a flag fault; it outranks data checks.
              fail_q  <= 1'b1;
              wr_q    <= 1'b0;
              state_q <= REPORT;
              done_q  <= 1'b1;
            end else if (i_q == LAST) begin
              wr_q    <= 1'b0;
              i_q     <= i_inc;
              state_q <= SETTLE_W;
            end else begin
              i_q       <= i_inc;
              wr_data_q <= pat(i_inc);
            end
          end
          SETTLE_W: begin
            if (!full || empty) fail_q <= 1'b1;
            i_q     <= '0;
            rd_q    <= 1'b1;
            state_q <= READ;
          end
          READ: begin
            if (empty) begin
              fail_q  <= 1'b1;
              rd_q    <= 1'b0;
              state_q <= REPORT;
              done_q  <= 1'b1;
            end else begin
              // A data mismatch is recorded but the drain continues to the end.
              if (rd_data != pat(i_q)) fail_q <= 1'b1;
              if (i_q == LAST) begin
                rd_q    <= 1'b0;
                state_q <= SETTLE_R;
              end else begin
                i_q <= i_inc;
              end
            end
          end
          SETTLE_R: begin
            if (!empty || full) fail_q <= 1'b1;
            state_q <= REPORT;
            done_q  <= 1'b1;
          end
          REPORT: begin
            // Hold here while en stays high so only one done pulse is produced.
            state_q <= REPORT;
          end
          default: begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
